alu_exec: RTL and testbench
===========================

# alu_exec

Execute-stage ALU for the 32-bit RISC-V core. Consumes operand A from register-file read port 1 and operand B from the ALU-source mux output (register read port 2 or immediate). Produces a registered result plus zero flag. Single-cycle ops complete in one clock; optional MUL runs as a 32-iteration shift-add sequence under a start/busy/done handshake.

## Interface
- XLEN, 32, operand/result width; only 32 is supported
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- alu_ctrl  input  4  opcode (see Operation)
- op_a  input  XLEN  operand A (register read port 1)
- op_b  input  XLEN  operand B (ALU-source mux output)
- result  output  XLEN  registered result, held until next completion
- zero  output  1  registered (result == 0), updates with result
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse: result/zero just updated
- err  output  1  registered; 1 when the completed op was an illegal opcode

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU, 1010 MUL (low 32 bits of product), 1011–1111 illegal.
- Shifts use op_b[4:0] only; SRA sign-fills from op_a[31].
- ADD/SUB wrap modulo 2^32; no overflow flag.
- SLT/SLTU produce 32'd0 or 32'd1.
- Illegal opcode: result=0, zero=1, err=1, single-cycle completion.
- FSM: IDLE, MUL_RUN.
  - IDLE + start + single-cycle op: latch result, zero, err; done=1; stay IDLE.
  - IDLE + start + MUL: load multiplicand/multiplier, clear accumulator, counter=0, busy=1 → MUL_RUN.
  - MUL_RUN: each cycle, add the shifted multiplicand when the multiplier LSB is 1, shift, counter++. When counter reaches 31 on that edge, latch result, done=1, busy=0 → IDLE.
- start while busy=1 is ignored (not queued). Upstream must hold the instruction until done.
- Operands are sampled only at acceptance. Changes to op_a/op_b during MUL_RUN have no effect.
- Reset values: result=0, zero=1, busy=0, done=0, err=0, state=IDLE, counter=0.

## Timing
- Acceptance edge E0 = first rising edge with start=1 and busy=0.
- Single-cycle ops: result/zero/err/done valid after E0. done drops after E1 unless another op is accepted at E1. Back-to-back single-cycle ops can be accepted every cycle.
- MUL: busy=1 after E0. Iterations run on E1..E32. Result and done are valid after E32, with busy=0 in the same cycle. Latency is 32 cycles.
- A new start in the cycle after MUL done is accepted (busy is already 0).
- rst asserted mid-MUL: at that edge, state→IDLE, busy=0, done=0, result=0. No partial result is exposed.
- rst and start in the same cycle: rst wins; start is dropped.

## Configuration
- ALU_MUL_EN defined: MUL opcode (1010), MUL_RUN state, counter and multiplier datapath are compiled in.
- ALU_MUL_EN undefined: 1010 is treated as illegal (result=0, err=1, single-cycle). busy is tied to 0 and the FSM reduces to IDLE only.

## Structure
- The shared package alu_pkg holds the opcode localparams (ALU_ADD … ALU_MUL), the FSM state encoding, and XLEN.
- Sub-module alu_mul_iter contains the shift-add multiplier: load, step, count, last flag. Instantiate it only under ALU_MUL_EN.
- The single-cycle datapath and FSM live in alu_exec.

## Test plan
- Reset: hold rst 2 cycles → result=0, zero=1, busy=0, done=0, err=0.
- Single-cycle ops: ADD 20+15 → 35, done after 1 edge. SUB 15-15 → 0 with zero=1. SRA 0x80000000 by 4 → 0xF8000000. SLT -1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
- MUL (ALU_MUL_EN defined): 20×15 → 300 with done exactly 32 edges after acceptance. 0xFFFFFFFF×2 → 0xFFFFFFFE. A start issued while busy is ignored and the result is unchanged.
- Back-to-back: ADD, XOR, OR started on consecutive cycles → three consecutive done pulses with correct results.
- Reset mid-MUL: assert rst at iteration 10 → busy=0, result=0, no done. A subsequent ADD 1+1 → 2.
- Illegal opcode 1111, and 1010 with ALU_MUL_EN undefined → result=0, zero=1, err=1, done after 1 edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operand width, opcode
// encodings and the FSM state type.
// Optional build macro: ALU_MUL_EN (enables the iterative multiplier).
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_RUN
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier core: one partial product per step, 32 steps give
// the low 32 bits of the product. prod_o presents the accumulator value
// including the current step, so the owner can capture it on the last step.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0] mplier_i,
  output logic [XLEN-1:0] prod_o,
  output logic            last_o
);

  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_d;
  logic [4:0]      count_q;

  // Accumulate the shifted multiplicand whenever the current multiplier bit is set
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  assign prod_o = acc_d;
  assign last_o = (count_q == 5'd31);

  // Load operands on acceptance, then advance one multiplier bit per step
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (load_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
      count_q  <= count_q + 5'd1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with registered result, zero and error flags.
// Single-cycle ops complete on the acceptance edge; MUL (when ALU_MUL_EN
// is defined) runs 32 shift-add iterations behind a busy/done handshake.
// Without ALU_MUL_EN, opcode 1010 is illegal and busy is constant 0.
module alu_exec
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          state_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            done_q;
  logic            err_q;
  logic [XLEN-1:0] scResult;
  logic            scIllegal;
  logic [4:0]      shamt;

  assign shamt = op_b[4:0];

  // Single-cycle datapath: opcode decode and result for every non-MUL op
  always_comb begin
    scResult  = '0;
    scIllegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  scResult = op_a + op_b;
      ALU_SUB:  scResult = op_a - op_b;
      ALU_AND:  scResult = op_a & op_b;
      ALU_OR:   scResult = op_a | op_b;
      ALU_XOR:  scResult = op_a ^ op_b;
      ALU_SLL:  scResult = op_a << shamt;
      ALU_SRL:  scResult = op_a >> shamt;
      ALU_SRA:  scResult = $signed(op_a) >>> shamt;
      ALU_SLT:  scResult = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: scResult = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  scIllegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic            busy_q;
  logic            mulLoad;
  logic            mulStep;
  logic            mulLast;
  logic [XLEN-1:0] mulProd;

  assign mulLoad = (state_q == ST_IDLE) && start && (alu_ctrl == ALU_MUL);
  assign mulStep = (state_q == ST_MUL_RUN);
  assign busy    = busy_q;

  alu_mul_iter u_mul (
    .clk      (clk),
    .rst      (rst),
    .load_i   (mulLoad),
    .step_i   (mulStep),
    .mcand_i  (op_a),
    .mplier_i (op_b),
    .prod_o   (mulProd),
    .last_o   (mulLast)
  );
`else
  assign busy = 1'b0;
`endif

  // Control FSM: accept requests in IDLE, wait out the multiplier in MUL_RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
`ifdef ALU_MUL_EN
            if (alu_ctrl == ALU_MUL) begin
              busy_q  <= 1'b1;
              state_q <= ST_MUL_RUN;
            end else
`endif
            begin
              result_q <= scResult;
              zero_q   <= (scResult == '0);
              err_q    <= scIllegal;
              done_q   <= 1'b1;
            end
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL_RUN: begin
          if (mulLast) begin
            result_q <= mulProd;
            zero_q   <= (mulProd == '0);
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: directed cases plus randomized operations checked
// against an arithmetic reference model. MUL-specific scenarios are built
// only when ALU_MUL_EN is defined.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  aluCtrl;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        err;

  int          totalCount = 0;
  int          badCount   = 0;
  logic [31:0] lastResult = 32'd0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctrl (aluCtrl),
    .op_a     (opA),
    .op_b     (opB),
    .result   (result),
    .zero     (zero),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Reference model: returns {err, result} for one completed operation
  function automatic logic [32:0] refAlu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] p;
    int          sa;
    int          sb;
    int          sh;
    sh = int'(b[4:0]);
    sa = a;
    sb = b;
    r  = 32'd0;
    case (ctrl)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd10: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
      end
`endif
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r};
  endfunction

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present a request to the ALU
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    aluCtrl = ctrl;
    opA     = a;
    opB     = b;
  endtask

  // Issue one op, wait for completion and check everything against the model
  task automatic runOp(input string tag, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] expv;
    bit          isMul;
    int          n;
    expv = refAlu(ctrl, a, b);
    isMul = 1'b0;
`ifdef ALU_MUL_EN
    isMul = (ctrl == 4'd10);
`endif
    applyStimulus(ctrl, a, b);
    @(posedge clk); #1;
    start = 1'b0;
    opA   = $urandom;
    opB   = $urandom;
    if (isMul) begin
      checkOutput({tag, ".busy"}, busy, 1);
      n = 0;
      while (!done && n < 40) begin
        checkOutput({tag, ".held"}, result, lastResult);
        @(posedge clk); #1;
        n++;
      end
      checkOutput({tag, ".latency"}, n, 32);
      checkOutput({tag, ".busyEnd"}, busy, 0);
    end
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".result"}, result, expv[31:0]);
    checkOutput({tag, ".zero"}, zero, (expv[31:0] == 32'd0));
    checkOutput({tag, ".err"}, err, expv[32]);
    lastResult = expv[31:0];
  endtask

  logic [3:0]  b2bCtrl [3] = '{4'd0, 4'd4, 4'd3};
  logic [31:0] b2bA    [3] = '{32'd100, 32'hF0F0_1234, 32'h0000_0F00};
  logic [31:0] b2bB    [3] = '{32'd23, 32'h0FF0_4321, 32'h0000_00F0};

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] e;
    int          n;
    bit          sawDone;

    rst = 1'b1; start = 1'b0; aluCtrl = 4'd0; opA = 32'd0; opB = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.result", result, 32'd0);
    checkOutput("reset.zero", zero, 1);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    runOp("add", 4'd0, 32'd20, 32'd15);
    @(posedge clk); #1;
    checkOutput("doneDrop", done, 0);
    runOp("subZero", 4'd1, 32'd15, 32'd15);
    runOp("sra", 4'd7, 32'h8000_0000, 32'd4);
    runOp("sllMask", 4'd5, 32'h0000_0003, 32'hFFFF_FFE4);
    runOp("slt", 4'd8, 32'hFFFF_FFFF, 32'd1);
    runOp("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1);
    runOp("illegal15", 4'd15, 32'd7, 32'd9);
    runOp("op1010", 4'd10, 32'd20, 32'd15);
    runOp("op1010big", 4'd10, 32'hFFFF_FFFF, 32'd2);

    // Three ops accepted on consecutive edges
    for (int i = 0; i < 3; i++) begin
      applyStimulus(b2bCtrl[i], b2bA[i], b2bB[i]);
      @(posedge clk); #1;
      e = refAlu(b2bCtrl[i], b2bA[i], b2bB[i]);
      checkOutput($sformatf("b2b%0d.done", i), done, 1);
      checkOutput($sformatf("b2b%0d.result", i), result, e[31:0]);
    end
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b.doneDrop", done, 0);

    // Reset and start in the same cycle: reset wins
    rst = 1'b1;
    applyStimulus(4'd0, 32'd5, 32'd5);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checkOutput("rstStart.done", done, 0);
    checkOutput("rstStart.result", result, 32'd0);
    checkOutput("rstStart.zero", zero, 1);
    lastResult = 32'd0;
    @(posedge clk); #1;
    checkOutput("rstStart.noLateDone", done, 0);

`ifdef ALU_MUL_EN
    // Start while busy is ignored; operand changes during the run are ignored
    applyStimulus(4'd10, 32'd20, 32'd15);
    @(posedge clk); #1;
    checkOutput("mulIgn.busy", busy, 1);
    n = 0;
    while (!done && n < 40) begin
      if (n == 5) begin
        applyStimulus(4'd0, 32'd1, 32'd2);
      end else begin
        start = 1'b0; aluCtrl = 4'd10; opA = $urandom; opB = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checkOutput("mulIgn.latency", n, 32);
    checkOutput("mulIgn.result", result, 32'd300);
    checkOutput("mulIgn.busyEnd", busy, 0);
    @(posedge clk); #1;
    checkOutput("mulIgn.notQueued", done, 0);
    checkOutput("mulIgn.busyAfter", busy, 0);
    checkOutput("mulIgn.kept", result, 32'd300);
    lastResult = 32'd300;

    // Reset in the middle of a multiply
    applyStimulus(4'd10, 32'd7, 32'd9);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstMul.busy", busy, 0);
    checkOutput("rstMul.done", done, 0);
    checkOutput("rstMul.result", result, 32'd0);
    lastResult = 32'd0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("rstMul.noDone", sawDone, 0);
`endif
    runOp("addAfterRst", 4'd0, 32'd1, 32'd1);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (rc == 4'd1 && $urandom_range(0, 4) == 0) rb = ra;
      runOp($sformatf("rand%0d", i), rc, ra, rb);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        checkOutput($sformatf("rand%0d.idle", i), done, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
